// File: rtl/acc_ctrl_pkg.sv
// Shared definitions for the accumulator machine sequencer:
// controller states, opcode encodings and a small opcode helper.
package acc_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_RST,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_HALT,
        ST_ERROR
    } state_t;

    localparam logic [2:0] OP_ADD   = 3'd0;
    localparam logic [2:0] OP_LOAD  = 3'd1;
    localparam logic [2:0] OP_STORE = 3'd2;
    localparam logic [2:0] OP_JMP   = 3'd3;
    localparam logic [2:0] OP_JZ    = 3'd4;
    localparam logic [2:0] OP_NOP   = 3'd5;
    localparam logic [2:0] OP_ILL   = 3'd6;
    localparam logic [2:0] OP_HALT  = 3'd7;

    // Opcodes whose EXEC phase waits for the memory handshake.
    function automatic logic is_mem_op(input logic [2:0] op);
        return (op == OP_LOAD) || (op == OP_STORE);
    endfunction

endpackage

// File: rtl/acc_wait_timer.sv
// Counts consecutive memory wait cycles and flags the cycle in which
// the TIMEOUT-th consecutive wait is seen (never when TIMEOUT is 0).
module acc_wait_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic ACTIVE = (TIMEOUT > 0);

    logic [CW-1:0] count;

    // count holds the number of earlier consecutive wait cycles
    assign expired = ACTIVE && enable && (count == LAST);

    // Wait counter: cleared whenever the wait is over, saturates at LAST
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != LAST)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/acc_seq_controller.sv
// Control sequencer for a simple accumulator machine:
// FETCH / DECODE / EXEC with memory wait handling, HALT and sticky ERROR.
module acc_seq_controller
    import acc_ctrl_pkg::*;
#(
    parameter int OPW     = 3,
    parameter int CNTW    = 16,
    parameter int TIMEOUT = 15
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [OPW-1:0]  opcode,
    input  logic            acc_zero,
    input  logic            mem_ready,
    input  logic            run,
    output logic            load_ir,
    output logic            load_acc,
    output logic            ld_pc,
    output logic            clr_pc,
    output logic            inc_pc,
    output logic            sel_alu,
    output logic            sel_bus,
    output logic            pass_add,
    output logic            ir_on_adr,
    output logic            pc_on_adr,
    output logic            mem_read,
    output logic            mem_write,
    output logic            halted,
    output logic            error,
    output logic [CNTW-1:0] retired
);

    state_t     state;
    state_t     state_nx;
    logic [2:0] op;
    logic       op_high;
    logic       wait_state;
    logic       waiting;
    logic       tmr_expired;
    logic       exec_done;

    assign op      = opcode[2:0];
    assign op_high = (opcode >> 3) != '0;

    assign wait_state = (state == ST_FETCH) ||
                        ((state == ST_EXEC) && is_mem_op(op));
    assign waiting    = wait_state && !mem_ready;
    assign exec_done  = (state == ST_EXEC) && (state_nx == ST_FETCH);

    acc_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clock   (clock),
        .reset   (reset),
        .clear   (!waiting),
        .enable  (waiting),
        .expired (tmr_expired)
    );

    // Next state and control strobes, decoded from the current state
    always_comb begin
        state_nx  = state;
        load_ir   = 1'b0;
        load_acc  = 1'b0;
        ld_pc     = 1'b0;
        clr_pc    = 1'b0;
        inc_pc    = 1'b0;
        sel_alu   = 1'b0;
        sel_bus   = 1'b0;
        pass_add  = 1'b0;
        ir_on_adr = 1'b0;
        pc_on_adr = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        halted    = 1'b0;
        error     = 1'b0;
        unique case (state)
            ST_RST: begin
                clr_pc   = 1'b1;
                state_nx = ST_FETCH;
            end
            ST_FETCH: begin
                pc_on_adr = 1'b1;
                mem_read  = 1'b1;
                if (mem_ready) begin
                    load_ir  = 1'b1;
                    inc_pc   = 1'b1;
                    state_nx = ST_DECODE;
                end else if (tmr_expired) begin
                    state_nx = ST_ERROR;
                end
            end
            ST_DECODE: begin
                if (op_high || (op == OP_ILL)) begin
                    state_nx = ST_ERROR;
                end else if (op == OP_HALT) begin
                    state_nx = ST_HALT;
                end else begin
                    state_nx = ST_EXEC;
                end
            end
            ST_EXEC: begin
                state_nx = ST_FETCH;
                case (op)
                    OP_ADD: begin
                        sel_alu  = 1'b1;
                        pass_add = 1'b1;
                        load_acc = 1'b1;
                    end
                    OP_LOAD: begin
                        ir_on_adr = 1'b1;
                        mem_read  = 1'b1;
                        sel_bus   = 1'b1;
                        load_acc  = mem_ready;
                    end
                    OP_STORE: begin
                        ir_on_adr = 1'b1;
                        mem_write = 1'b1;
                    end
                    OP_JMP: begin
                        ld_pc     = 1'b1;
                        ir_on_adr = 1'b1;
                    end
                    OP_JZ: begin
                        ld_pc     = acc_zero;
                        ir_on_adr = acc_zero;
                    end
                    default: begin
                    end
                endcase
                if (is_mem_op(op) && !mem_ready) begin
                    state_nx = tmr_expired ? ST_ERROR : ST_EXEC;
                end
            end
            ST_HALT: begin
                halted = 1'b1;
                if (run) begin
                    state_nx = ST_FETCH;
                end
            end
            ST_ERROR: begin
                error = 1'b1;
            end
            default: begin
                state_nx = ST_ERROR;
            end
        endcase
    end

    // State register and retired-instruction counter
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= ST_RST;
            retired <= '0;
        end else begin
            state <= state_nx;
            if (exec_done) begin
                retired <= retired + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_acc_seq_controller.sv
// Randomized instruction-level bench for acc_seq_controller.
// Expected strobes are derived per instruction phase from the ISA rules.
module tb_acc_seq_controller;

    localparam int OPW     = 4;
    localparam int CNTW    = 4;
    localparam int TIMEOUT = 15;

    localparam logic [13:0] O_LOAD_IR  = 14'h2000;
    localparam logic [13:0] O_LOAD_ACC = 14'h1000;
    localparam logic [13:0] O_LD_PC    = 14'h0800;
    localparam logic [13:0] O_CLR_PC   = 14'h0400;
    localparam logic [13:0] O_INC_PC   = 14'h0200;
    localparam logic [13:0] O_SEL_ALU  = 14'h0100;
    localparam logic [13:0] O_SEL_BUS  = 14'h0080;
    localparam logic [13:0] O_PASS_ADD = 14'h0040;
    localparam logic [13:0] O_IR_ADR   = 14'h0020;
    localparam logic [13:0] O_PC_ADR   = 14'h0010;
    localparam logic [13:0] O_MEM_RD   = 14'h0008;
    localparam logic [13:0] O_MEM_WR   = 14'h0004;
    localparam logic [13:0] O_HALTED   = 14'h0002;
    localparam logic [13:0] O_ERROR    = 14'h0001;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic [OPW-1:0]  opcode = '0;
    logic            acc_zero = 1'b0;
    logic            mem_ready = 1'b0;
    logic            run = 1'b0;
    logic            load_ir, load_acc, ld_pc, clr_pc, inc_pc;
    logic            sel_alu, sel_bus, pass_add, ir_on_adr, pc_on_adr;
    logic            mem_read, mem_write, halted, error;
    logic [CNTW-1:0] retired;
    logic [13:0]     outs;

    int n_vec = 0;
    int n_err = 0;
    int rcount = 0;

    acc_seq_controller #(
        .OPW     (OPW),
        .CNTW    (CNTW),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .opcode    (opcode),
        .acc_zero  (acc_zero),
        .mem_ready (mem_ready),
        .run       (run),
        .load_ir   (load_ir),
        .load_acc  (load_acc),
        .ld_pc     (ld_pc),
        .clr_pc    (clr_pc),
        .inc_pc    (inc_pc),
        .sel_alu   (sel_alu),
        .sel_bus   (sel_bus),
        .pass_add  (pass_add),
        .ir_on_adr (ir_on_adr),
        .pc_on_adr (pc_on_adr),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .halted    (halted),
        .error     (error),
        .retired   (retired)
    );

    assign outs = {load_ir, load_acc, ld_pc, clr_pc, inc_pc, sel_alu,
                   sel_bus, pass_add, ir_on_adr, pc_on_adr, mem_read,
                   mem_write, halted, error};

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // One clock: check strobes and retired mid-cycle, then advance.
    task automatic cyc(input string tag, input logic [13:0] exp);
        @(negedge clock);
        check({tag, "_out"}, 32'(outs), 32'(exp));
        check({tag, "_ret"}, 32'(retired), 32'(rcount));
        @(posedge clock);
        #1;
    endtask

    task automatic retire();
        rcount = (rcount + 1) % (1 << CNTW);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        mem_ready = 1'($urandom);
        run = 1'($urandom);
        #1;
        check("rst_out", 32'(outs), 32'(O_CLR_PC));
        check("rst_ret", 32'(retired), 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        rcount = 0;
        cyc("rst_rel", O_CLR_PC);
    endtask

    task automatic err_seq();
        for (int i = 0; i < 3; i++) begin
            run = 1'($urandom);
            mem_ready = 1'($urandom);
            acc_zero = 1'($urandom);
            opcode = OPW'($urandom);
            cyc("error", O_ERROR);
        end
        do_reset();
    endtask

    task automatic halt_seq();
        int n;
        n = $urandom_range(0, 3);
        for (int i = 0; i < n; i++) begin
            run = 1'b0;
            mem_ready = 1'($urandom);
            cyc("halt", O_HALTED);
        end
        run = 1'b1;
        cyc("halt_run", O_HALTED);
        run = 1'b0;
    endtask

    task automatic do_fetch(input int fw, input logic [OPW-1:0] op,
                            output bit died);
        died = 1'b0;
        for (int i = 0; i < fw; i++) begin
            mem_ready = 1'b0;
            opcode = OPW'($urandom);
            run = 1'($urandom);
            acc_zero = 1'($urandom);
            cyc("fetch_wait", O_PC_ADR | O_MEM_RD);
            if (i == TIMEOUT - 1) begin
                died = 1'b1;
                return;
            end
        end
        mem_ready = 1'b1;
        opcode = op;
        run = 1'b0;
        cyc("fetch_rdy", O_PC_ADR | O_MEM_RD | O_LOAD_IR | O_INC_PC);
    endtask

    task automatic do_mem(input string tag, input logic [13:0] base,
                          input logic [13:0] fin, input int ew,
                          output bit died);
        died = 1'b0;
        for (int i = 0; i < ew; i++) begin
            mem_ready = 1'b0;
            acc_zero = 1'($urandom);
            cyc({tag, "_wait"}, base);
            if (i == TIMEOUT - 1) begin
                died = 1'b1;
                return;
            end
        end
        mem_ready = 1'b1;
        cyc({tag, "_rdy"}, base | fin);
        retire();
    endtask

    task automatic do_exec(input logic [2:0] op, input int ew,
                           output bit died);
        logic az;
        died = 1'b0;
        mem_ready = 1'($urandom);
        case (op)
            3'd0: begin
                cyc("add", O_SEL_ALU | O_PASS_ADD | O_LOAD_ACC);
                retire();
            end
            3'd1: do_mem("load", O_IR_ADR | O_MEM_RD | O_SEL_BUS,
                         O_LOAD_ACC, ew, died);
            3'd2: do_mem("store", O_IR_ADR | O_MEM_WR, '0, ew, died);
            3'd3: begin
                cyc("jmp", O_LD_PC | O_IR_ADR);
                retire();
            end
            3'd4: begin
                az = 1'($urandom);
                acc_zero = az;
                cyc("jz", az ? (O_LD_PC | O_IR_ADR) : 14'h0);
                retire();
            end
            default: begin
                cyc("nop", 14'h0);
                retire();
            end
        endcase
    endtask

    task automatic instr(input logic [OPW-1:0] op, input int fw,
                         input int ew);
        bit died;
        do_fetch(fw, op, died);
        if (died) begin
            err_seq();
            return;
        end
        mem_ready = 1'($urandom);
        acc_zero = 1'($urandom);
        run = 1'($urandom);
        cyc("decode", 14'h0);
        run = 1'b0;
        if (op == OPW'(7)) begin
            halt_seq();
        end else if (op >= OPW'(6)) begin
            err_seq();
        end else begin
            do_exec(op[2:0], ew, died);
            if (died) err_seq();
        end
    endtask

    task automatic jz_fixed(input logic az);
        bit died;
        do_fetch(0, OPW'(4), died);
        cyc("decode", 14'h0);
        acc_zero = az;
        cyc("jz_dir", az ? (O_LD_PC | O_IR_ADR) : 14'h0);
        retire();
    endtask

    task automatic store_reset();
        bit died;
        do_fetch(1, OPW'(2), died);
        cyc("decode", 14'h0);
        mem_ready = 1'b0;
        cyc("st_wait", O_IR_ADR | O_MEM_WR);
        @(negedge clock);
        check("st_mid", 32'(outs), 32'(O_IR_ADR | O_MEM_WR));
        #2;
        reset = 1'b1;
        #1;
        check("st_rst_out", 32'(outs), 32'(O_CLR_PC));
        check("st_rst_ret", 32'(retired), 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        rcount = 0;
        cyc("rst_rel", O_CLR_PC);
    endtask

    initial begin
        logic [OPW-1:0] op;
        int r, fw, ew;
        #1;
        do_reset();
        for (int i = 0; i < 4; i++) instr(OPW'(0), 0, 0);
        instr(OPW'(1), 0, 3);
        instr(OPW'(2), 2, 1);
        jz_fixed(1'b0);
        jz_fixed(1'b1);
        instr(OPW'(3), 1, 0);
        instr(OPW'(7), 0, 0);
        instr(OPW'(5), 0, 0);
        instr(OPW'(6), 0, 0);
        instr(OPW'(9), 0, 0);
        instr(OPW'(1), TIMEOUT - 1, 0);
        instr(OPW'(2), 0, TIMEOUT - 1);
        instr(OPW'(0), TIMEOUT, 0);
        instr(OPW'(1), 0, TIMEOUT);
        for (int i = 0; i < 16; i++) instr(OPW'(5), 0, 0);
        instr(OPW'(0), 0, 0);
        store_reset();
        for (int k = 0; k < 300; k++) begin
            r = $urandom_range(0, 19);
            if (r < 14) op = OPW'(r % 6);
            else if (r < 16) op = OPW'(7);
            else op = OPW'($urandom_range(6, 15));
            fw = ($urandom_range(0, 9) == 0) ? $urandom_range(13, 16)
                                              : $urandom_range(0, 3);
            ew = ($urandom_range(0, 9) == 0) ? $urandom_range(13, 16)
                                              : $urandom_range(0, 3);
            instr(op, fw, ew);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
